rng_ram_fill: RTL and testbench
===============================

Name: rng_ram_fill

Overview:
- Parametrised dual-port random-word store with an internal DEPTH x DW memory and two pipelined Wishbone ports (A, B).
- A block-fill engine writes a contiguous, wrapping address range from an external entropy stream using a valid/ready handshake.
- Fill writes share port A's write path. When a fill write takes the path, port A is stalled rather than silently blocked.
- Sits between the TRNG word generator and the bus masters that consume random words.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 9, address width in bits; DEPTH = 2**AW words.
- SW, DW/8, number of byte-enable bits (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- pA_wb_cyc_i, pA_wb_stb_i  in  1 each  port A cycle and strobe.
- pA_wb_we_i  in  SW  port A byte write enables; all-zero means read.
- pA_wb_addr_i  in  AW  port A word address.
- pA_wb_data_i  in  DW  port A write data.
- pA_wb_ack_o  out  1  port A acknowledge.
- pA_wb_stall_o  out  1  port A stall.
- pA_wb_data_o  out  DW  port A read data.
- pB_wb_*  same seven signals, same widths, for port B.
- ent_valid_i  in  1  entropy word valid.
- ent_data_i  in  DW  entropy word.
- ent_ready_o  out  1  engine accepts an entropy word.
- fill_req_i  in  1  start-fill request, sampled in IDLE only.
- fill_base_i  in  AW  first address of the fill.
- fill_len_i  in  AW+1  words to fill; values above DEPTH clamp to DEPTH.
- fill_busy_o  out  1  high while state != IDLE.
- fill_done_o  out  1  one-cycle completion pulse.
- fill_count_o  out  AW+1  words written by the current or last fill.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Memory contents are not reset. A reset mid-fill abandons the fill; words already written are retained.
- Wishbone acceptance: a request is accepted when cyc & stb & !stall.
  - ack is asserted exactly one cycle after acceptance; the bus is pipelined, one request per cycle.
  - Read data is valid in the ack cycle; data_o holds its value between acks.
  - Writes update only the bytes whose we bit is set.
- Port B: pB_wb_stall_o is tied to 0.
- Port A: pA_wb_stall_o = (state==FILL) & ent_valid_i (combinational).
  - A request accepted before a stall still gets its ack.
  - Port A gains access in every cycle where the entropy stream has a gap.
- Same-address events in one cycle:
  - A read returns the old data (read-first).
  - If port A (or a fill write) and port B both write, the port A / fill write wins.
- FSM states: IDLE, FILL, DONE.
  - IDLE, fill_req_i with clamped len != 0: latch ptr = fill_base_i, rem = len; clear fill_count_o; go to FILL.
  - IDLE, fill_req_i with len == 0: fill_count_o = 0; fill_done_o pulses in the next cycle; stay in IDLE.
  - FILL: ent_ready_o = 1. On ent_valid_i, write ent_data_i (all bytes) to mem[ptr]; ptr = ptr+1 mod DEPTH (wraps from DEPTH-1 to 0); rem -= 1; fill_count_o += 1. When rem==1 at that write, go to DONE.
  - DONE: fill_done_o = 1 for this cycle only, then go to IDLE.
  - fill_req_i outside IDLE is ignored.
  - ent_ready_o is 0 outside FILL.
- Fill latency: fill_done_o is asserted in the cycle after the last entropy word is accepted.
- fill_count_o holds its value until the next accepted fill_req_i.

Optional Feature:
- Macro: RNG_RAM_BURN_ON_READ_EN.
- Defined: an accepted port B read (we == 0) returns the stored word and, in the same cycle, writes all-zero to that address (read-once random words).
  - A port A or fill write to the same address in that cycle overrides the burn.
- Undefined: port B reads are non-destructive.

Test Plan:
- Reset: assert rst_i for 2 cycles during traffic -> all outputs 0, FSM in IDLE, ent_ready_o = 0.
- Wrapping fill: base = 0x1F0, len = 32, ent_data = 0x10000000+i, valid every cycle.
  - Reads return: 0x1FF -> 0x1000000F, 0x000 -> 0x10000010, 0x00F -> 0x1000001F.
  - fill_done_o is a single pulse one cycle after the 32nd word; fill_count_o = 32.
- Stall interplay: port A write held during a fill with ent_valid_i toggling 1,0,1,0 -> stall follows ent_valid_i, the write is accepted in the first gap cycle, and ack arrives one cycle later.
- Byte enables: write 0xDEADBEEF with we=1111 to 0x010, then 0x00005500 with we=0010 -> read returns 0xDEAD55EF.
- Collision: same cycle, A writes 0x11111111 and B writes 0x22222222 to 0x020, and a concurrent A read of 0x021 -> 0x020 reads back 0x11111111; the 0x021 read returns its old data.
- Burn / len edge cases:
  - With macro, two B reads of 0x030 (holding 0xCAFEF00D) -> 0xCAFEF00D then 0x00000000; without macro, both return 0xCAFEF00D.
  - len = 0 -> done pulse next cycle, count = 0.
  - len = 1023 -> clamps to 512 writes.

Source files
------------

// File: rtl/rng_ram_fill.sv
// Dual-port Wishbone random-word store with an entropy-driven block-fill engine.
// Define RNG_RAM_BURN_ON_READ_EN to make port B reads destructive (read-once words).
module rng_ram_fill #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 9,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pA_wb_cyc_i,
  input  logic          pA_wb_stb_i,
  input  logic [SW-1:0] pA_wb_we_i,
  input  logic [AW-1:0] pA_wb_addr_i,
  input  logic [DW-1:0] pA_wb_data_i,
  output logic          pA_wb_ack_o,
  output logic          pA_wb_stall_o,
  output logic [DW-1:0] pA_wb_data_o,
  input  logic          pB_wb_cyc_i,
  input  logic          pB_wb_stb_i,
  input  logic [SW-1:0] pB_wb_we_i,
  input  logic [AW-1:0] pB_wb_addr_i,
  input  logic [DW-1:0] pB_wb_data_i,
  output logic          pB_wb_ack_o,
  output logic          pB_wb_stall_o,
  output logic [DW-1:0] pB_wb_data_o,
  input  logic          ent_valid_i,
  input  logic [DW-1:0] ent_data_i,
  output logic          ent_ready_o,
  input  logic          fill_req_i,
  input  logic [AW-1:0] fill_base_i,
  input  logic [AW:0]   fill_len_i,
  output logic          fill_busy_o,
  output logic          fill_done_o,
  output logic [AW:0]   fill_count_o
);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          zdone_q, zdone_d;
  logic [AW:0]   len_clamped;
  logic          acc_a, acc_b, fill_wr;
  logic [DW-1:0] mem [DEPTH];

  assign len_clamped   = (fill_len_i > DEPTH_W) ? DEPTH_W : fill_len_i;
  assign fill_wr       = (state_q == FILL) && ent_valid_i;
  assign pA_wb_stall_o = fill_wr;
  assign pB_wb_stall_o = 1'b0;
  assign acc_a         = pA_wb_cyc_i && pA_wb_stb_i && !pA_wb_stall_o;
  assign acc_b         = pB_wb_cyc_i && pB_wb_stb_i;
  assign ent_ready_o   = (state_q == FILL);
  assign fill_busy_o   = (state_q != IDLE);
  // A zero-length request never leaves IDLE, so its done pulse comes from a flag.
  assign fill_done_o   = (state_q == DONE) || zdone_q;
  assign fill_count_o  = cnt_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_req_i) begin
          cnt_d = '0;
          if (len_clamped != '0) begin
            ptr_d   = fill_base_i;
            rem_d   = len_clamped;
            state_d = FILL;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (ent_valid_i) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (rem_q == (AW+1)'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zdone_q <= zdone_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pA_wb_ack_o  <= 1'b0;
      pB_wb_ack_o  <= 1'b0;
      pA_wb_data_o <= '0;
      pB_wb_data_o <= '0;
    end else begin
      pA_wb_ack_o <= acc_a;
      pB_wb_ack_o <= acc_b;
      if (acc_a && (pA_wb_we_i == '0)) pA_wb_data_o <= mem[pA_wb_addr_i];
      if (acc_b && (pB_wb_we_i == '0)) pB_wb_data_o <= mem[pB_wb_addr_i];
    end
  end

  // Write order sets priority on a shared address: B (or burn) first, then A/fill override.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
`ifdef RNG_RAM_BURN_ON_READ_EN
      if (acc_b && (pB_wb_we_i == '0)) mem[pB_wb_addr_i] <= '0;
`endif
      for (int unsigned i = 0; i < SW; i++) begin
        if (acc_b && pB_wb_we_i[i]) mem[pB_wb_addr_i][8*i +: 8] <= pB_wb_data_i[8*i +: 8];
      end
      for (int unsigned i = 0; i < SW; i++) begin
        if (acc_a && pA_wb_we_i[i]) mem[pA_wb_addr_i][8*i +: 8] <= pA_wb_data_i[8*i +: 8];
      end
      if (fill_wr) mem[ptr_q] <= ent_data_i;
    end
  end
endmodule

// File: tb/tb_rng_ram_fill.sv
// Scoreboard bench for rng_ram_fill: driver updates a word-array model and queues
// expected acks/done pulses; a posedge monitor pops and compares.
module tb_rng_ram_fill;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned SW = 4;
  localparam int unsigned DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  logic pA_cyc, pA_stb, pA_ack, pA_stall, pB_cyc, pB_stb, pB_ack, pB_stall;
  logic [SW-1:0] pA_we, pB_we;
  logic [AW-1:0] pA_addr, pB_addr, fill_base;
  logic [DW-1:0] pA_wdat, pA_rdat, pB_wdat, pB_rdat, ent_data;
  logic ent_valid, ent_ready, fill_req, fill_busy, fill_done;
  logic [AW:0] fill_len, fill_count;

  rng_ram_fill #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .pA_wb_cyc_i(pA_cyc), .pA_wb_stb_i(pA_stb), .pA_wb_we_i(pA_we), .pA_wb_addr_i(pA_addr),
    .pA_wb_data_i(pA_wdat), .pA_wb_ack_o(pA_ack), .pA_wb_stall_o(pA_stall), .pA_wb_data_o(pA_rdat),
    .pB_wb_cyc_i(pB_cyc), .pB_wb_stb_i(pB_stb), .pB_wb_we_i(pB_we), .pB_wb_addr_i(pB_addr),
    .pB_wb_data_i(pB_wdat), .pB_wb_ack_o(pB_ack), .pB_wb_stall_o(pB_stall), .pB_wb_data_o(pB_rdat),
    .ent_valid_i(ent_valid), .ent_data_i(ent_data), .ent_ready_o(ent_ready),
    .fill_req_i(fill_req), .fill_base_i(fill_base), .fill_len_i(fill_len),
    .fill_busy_o(fill_busy), .fill_done_o(fill_done), .fill_count_o(fill_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { int unsigned cyc; logic rd; logic [DW-1:0] d; } exp_t;
  typedef struct packed { int unsigned cyc; logic [AW:0] cnt; } dexp_t;

  exp_t  qa[$], qb[$];
  dexp_t qd[$];
  int unsigned n_cmp = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] model [DEPTH];

  logic a_req, b_req, ent_v, f_req;
  logic [SW-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr, f_base;
  logic [DW-1:0] a_dat, b_dat, ent_d;
  logic [AW:0] f_len;
  logic fill_on, in_done;
  logic [AW-1:0] f_ptr;
  logic [AW:0] f_rem, f_cnt;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin : monitor
    logic ea, eb, ed;
    exp_t e;
    dexp_t de;
    cyc++;
    #1;
    ea = (qa.size() != 0) && (qa[0].cyc == cyc);
    check("ackA", DW'(pA_ack), DW'(ea));
    if (ea) begin
      e = qa.pop_front();
      if (e.rd) check("rdataA", pA_rdat, e.d);
    end
    eb = (qb.size() != 0) && (qb[0].cyc == cyc);
    check("ackB", DW'(pB_ack), DW'(eb));
    if (eb) begin
      e = qb.pop_front();
      if (e.rd) check("rdataB", pB_rdat, e.d);
    end
    ed = (qd.size() != 0) && (qd[0].cyc == cyc);
    check("fill_done", DW'(fill_done), DW'(ed));
    if (ed) begin
      de = qd.pop_front();
      check("fill_count", DW'(fill_count), DW'(de.cnt));
    end
  end

  // One clock of stimulus: drive at negedge, predict the effect of the next posedge.
  task automatic tick();
    logic stall_e, a_acc, busy_start;
    logic [AW:0] lenc;
    exp_t e;
    dexp_t de;
    @(negedge clk);
    pA_cyc = a_req; pA_stb = a_req; pA_we = a_we; pA_addr = a_addr; pA_wdat = a_dat;
    pB_cyc = b_req; pB_stb = b_req; pB_we = b_we; pB_addr = b_addr; pB_wdat = b_dat;
    ent_valid = ent_v; ent_data = ent_d;
    fill_req = f_req; fill_base = f_base; fill_len = f_len;
    #1;
    busy_start = fill_on || in_done;
    stall_e = fill_on && ent_v;
    check("stallA", DW'(pA_stall), DW'(stall_e));
    check("stallB", DW'(pB_stall), '0);
    check("ent_ready", DW'(ent_ready), DW'(fill_on));
    check("busy", DW'(fill_busy), DW'(busy_start));
    in_done = 1'b0;
    a_acc = a_req && !stall_e;
    if (a_acc) begin
      e.cyc = cyc + 1; e.rd = (a_we == '0); e.d = model[a_addr];
      qa.push_back(e);
    end
    if (b_req) begin
      e.cyc = cyc + 1; e.rd = (b_we == '0); e.d = model[b_addr];
      qb.push_back(e);
`ifdef RNG_RAM_BURN_ON_READ_EN
      if (b_we == '0) model[b_addr] = '0;
`endif
      for (int unsigned i = 0; i < SW; i++)
        if (b_we[i]) model[b_addr][8*i +: 8] = b_dat[8*i +: 8];
    end
    if (a_acc)
      for (int unsigned i = 0; i < SW; i++)
        if (a_we[i]) model[a_addr][8*i +: 8] = a_dat[8*i +: 8];
    if (fill_on && ent_v) begin
      model[f_ptr] = ent_d;
      f_ptr = f_ptr + 1'b1;
      f_rem = f_rem - 1'b1;
      f_cnt = f_cnt + 1'b1;
      if (f_rem == '0) begin
        fill_on = 1'b0;
        in_done = 1'b1;
        de.cyc = cyc + 1; de.cnt = f_cnt;
        qd.push_back(de);
      end
    end
    if (f_req && !busy_start) begin
      lenc = (f_len > 10'd512) ? 10'd512 : f_len;
      if (lenc == '0) begin
        de.cyc = cyc + 1; de.cnt = '0;
        qd.push_back(de);
      end else begin
        fill_on = 1'b1; f_ptr = f_base; f_rem = lenc; f_cnt = '0;
      end
    end
    if (a_acc) a_req = 1'b0;
    b_req = 1'b0;
    f_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pA_cyc = 1'b1; pA_stb = 1'b1; pA_we = SW'($urandom); pA_addr = AW'($urandom); pA_wdat = $urandom;
    pB_cyc = 1'b1; pB_stb = 1'b1; pB_we = SW'($urandom); pB_addr = AW'($urandom); pB_wdat = $urandom;
    ent_valid = 1'b1; ent_data = $urandom; fill_req = 1'b1; fill_base = '0; fill_len = 10'd5;
    a_req = 1'b0; b_req = 1'b0; f_req = 1'b0; ent_v = 1'b0;
    fill_on = 1'b0; in_done = 1'b0;
    qa.delete(); qb.delete(); qd.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ackA", DW'(pA_ack), '0);
    check("rst_ackB", DW'(pB_ack), '0);
    check("rst_stallA", DW'(pA_stall), '0);
    check("rst_dataA", pA_rdat, '0);
    check("rst_dataB", pB_rdat, '0);
    check("rst_ready", DW'(ent_ready), '0);
    check("rst_busy", DW'(fill_busy), '0);
    check("rst_done", DW'(fill_done), '0);
    check("rst_count", DW'(fill_count), '0);
    rst = 1'b0;
    pA_cyc = 1'b0; pA_stb = 1'b0; pB_cyc = 1'b0; pB_stb = 1'b0;
    ent_valid = 1'b0; fill_req = 1'b0;
  endtask

  task automatic opA(input logic [AW-1:0] ad, input logic [SW-1:0] we, input logic [DW-1:0] d);
    a_req = 1'b1; a_we = we; a_addr = ad; a_dat = d;
    for (int n = 0; n < 64 && a_req; n++) tick();
    if (a_req) begin fail_timeout("portA_request"); a_req = 1'b0; end
  endtask

  task automatic opB(input logic [AW-1:0] ad, input logic [SW-1:0] we, input logic [DW-1:0] d);
    b_req = 1'b1; b_we = we; b_addr = ad; b_dat = d;
    tick();
  endtask

  task automatic run_fill(input logic [AW-1:0] base, input logic [AW:0] len, input bit pat, input bit gappy);
    f_req = 1'b1; f_base = base; f_len = len; ent_v = 1'b0;
    tick();
    for (int n = 0; n < 3000 && (fill_on || in_done); n++) begin
      ent_v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      ent_d = pat ? (32'h1000_0000 + DW'(f_cnt)) : $urandom;
      tick();
    end
    if (fill_on || in_done) fail_timeout("fill_complete");
    ent_v = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pA_cyc = 0; pA_stb = 0; pA_we = '0; pA_addr = '0; pA_wdat = '0;
    pB_cyc = 0; pB_stb = 0; pB_we = '0; pB_addr = '0; pB_wdat = '0;
    ent_valid = 0; ent_data = '0; fill_req = 0; fill_base = '0; fill_len = '0;
    a_req = 0; b_req = 0; ent_v = 0; f_req = 0;
    a_we = '0; b_we = '0; a_addr = '0; b_addr = '0; a_dat = '0; b_dat = '0; ent_d = '0;
    f_base = '0; f_len = '0; fill_on = 0; in_done = 0; f_ptr = '0; f_rem = '0; f_cnt = '0;
    do_reset();

    // Oversized length clamps to a full-memory fill, which also defines every word.
    run_fill(9'h000, 10'd1023, 1'b0, 1'b1);

    // Wrapping fill with a counting pattern.
    run_fill(9'h1F0, 10'd32, 1'b1, 1'b0);
    opA(9'h1FF, '0, '0);
    opA(9'h000, '0, '0);
    opA(9'h00F, '0, '0);
    opA(9'h1F0, '0, '0);

    // Port A write held across a fill with a toggling entropy stream.
    f_req = 1'b1; f_base = 9'h100; f_len = 10'd4; ent_v = 1'b0;
    tick();
    a_req = 1'b1; a_we = '1; a_addr = 9'h140; a_dat = 32'hA5A5_5A5A;
    for (int n = 0; n < 40 && (fill_on || in_done || a_req); n++) begin
      ent_v = (n % 2 == 0); ent_d = $urandom;
      tick();
    end
    if (fill_on || in_done || a_req) fail_timeout("stall_sequence");
    ent_v = 1'b0;
    opA(9'h140, '0, '0);
    opA(9'h101, '0, '0);

    // Byte enables.
    opA(9'h010, 4'b1111, 32'hDEAD_BEEF);
    opA(9'h010, 4'b0010, 32'h0000_5500);
    opA(9'h010, '0, '0);

    // Same-cycle collisions: write/write, then read-first against a concurrent write.
    a_req = 1'b1; a_we = '1; a_addr = 9'h020; a_dat = 32'h1111_1111;
    opB(9'h020, '1, 32'h2222_2222);
    a_req = 1'b1; a_we = '0; a_addr = 9'h021;
    opB(9'h021, '1, 32'h3333_3333);
    opA(9'h020, '0, '0);
    opA(9'h021, '0, '0);

    // Port B repeated read of one word (destructive only when burn is built in).
    opA(9'h030, '1, 32'hCAFE_F00D);
    opB(9'h030, '0, '0);
    opB(9'h030, '0, '0);
    tick();

    // Zero-length fill.
    run_fill(9'h055, 10'd0, 1'b0, 1'b0);
    tick();
    check("count_len0", DW'(fill_count), '0);

    // Randomized mixed traffic with fills starting at arbitrary times.
    for (int n = 0; n < 600; n++) begin
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1'b1;
        a_we = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom);
        a_addr = AW'($urandom_range(0, 31)); a_dat = $urandom;
      end
      b_req = ($urandom_range(0, 2) == 0);
      b_we = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom);
      b_addr = AW'($urandom_range(0, 31)); b_dat = $urandom;
      ent_v = 1'($urandom_range(0, 1)); ent_d = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        f_req = 1'b1; f_base = AW'($urandom_range(500, 520)); f_len = (AW+1)'($urandom_range(0, 24));
      end
      tick();
    end
    for (int n = 0; n < 64 && (a_req || fill_on || in_done); n++) begin
      ent_v = 1'b1; ent_d = $urandom;
      tick();
    end
    ent_v = 1'b0;

    // Reset in the middle of a fill with bus traffic; written words must survive.
    f_req = 1'b1; f_base = 9'h080; f_len = 10'd100; ent_v = 1'b0;
    tick();
    for (int n = 0; n < 9; n++) begin
      ent_v = 1'b1; ent_d = $urandom;
      tick();
    end
    do_reset();
    opA(9'h080, '0, '0);
    opA(9'h088, '0, '0);
    opA(9'h089, '0, '0);

    repeat (4) tick();
    check("queues_drained", DW'(qa.size() + qb.size() + qd.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
